// File: rtl/port_serial_tx.sv
// Nibble-wide serial transmitter for the CPU output port.
// A 4-entry FIFO buffers CPU writes. A UART-style framer sends each nibble as
// start(0), 4 data bits LSB first, an optional even parity bit, and stop(1).
// Each bit lasts CLKS_PER_BIT clock cycles.
module port_serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       out_tx,
    output logic       out_busy,
    output logic [2:0] out_count,
    output logic       out_overflow
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

    state_t     state_q, state_d;
    logic [7:0] baud_q, baud_d;
    logic [1:0] bit_idx_q, bit_idx_d;
    logic [3:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic       tx_q, tx_d;
    logic       ovf_q, ovf_d;

    logic [3:0] mem_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q, count_d;

    logic       pop;
    logic       push;
    logic       fifo_empty;
    logic       fifo_full;
    logic       baud_done;
    logic [3:0] head;

    // FIFO status and bit-period timing flags
    always_comb begin
        fifo_empty = (count_q == 3'd0);
        fifo_full  = (count_q == 3'd4);
        baud_done  = (baud_q == BAUD_LAST);
        head       = mem_q[rd_ptr_q];
    end

    // Framer next-state logic; pop loads the shift register and parity
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + 8'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_d   = START;
                    shift_d   = head;
                    parity_d  = ^head;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 2'd3) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 2'd1;
                        shift_d   = {1'b0, shift_q[3:1]};
                    end
                end
            end
            PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_d   = START;
                        shift_d   = head;
                        parity_d  = ^head;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Line level is decoded from the next state so out_tx comes straight from a flop
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO accept/drop decision; a same-edge pop frees a slot when full
    always_comb begin
        push  = in_valid && (!fifo_full || pop);
        ovf_d = in_valid && fifo_full && !pop;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= in_data;
    end

    assign out_tx       = tx_q;
    assign out_overflow = ovf_q;
    assign out_count    = count_q;
    assign out_busy     = (state_q != IDLE) || (count_q != 3'd0);

endmodule

// File: tb/tb_port_serial_tx.sv
// Bench for port_serial_tx with CLKS_PER_BIT=4 and PARITY_EN=1.
module tb_port_serial_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_data;
    logic       in_valid;
    logic       out_tx;
    logic       out_busy;
    logic [2:0] out_count;
    logic       out_overflow;

    int tests = 0;
    int fails = 0;

    port_serial_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .out_tx(out_tx),
        .out_busy(out_busy),
        .out_count(out_count),
        .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending nibbles and a queue of line levels
    // for the rest of the frame now on the wire (one entry per clock cycle).
    logic [3:0] mq[$];
    logic       wave[$];
    logic       m_ovf = 1'b0;

    typedef struct {
        logic [3:0] data;
        logic [6:0] bits;   // bit period levels, [0]=start ... [6]=stop
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic v, input logic [3:0] d, input logic r);
        logic popq;
        logic full;
        logic [3:0] n;
        if (r) begin
            mq.delete();
            wave.delete();
            m_ovf = 1'b0;
        end else begin
            popq  = (wave.size() <= 1) && (mq.size() > 0);
            full  = (mq.size() == 4);
            m_ovf = v && full && !popq;
            if (wave.size() > 0) void'(wave.pop_front());
            if (popq) begin
                n = mq.pop_front();
                for (int b = 0; b < 7; b++) begin
                    logic lvl;
                    if (b == 0)      lvl = 1'b0;
                    else if (b <= 4) lvl = n[b-1];
                    else if (b == 5) lvl = ^n;
                    else             lvl = 1'b1;
                    for (int k = 0; k < C; k++) wave.push_back(lvl);
                end
            end
            if (v && (!full || popq)) mq.push_back(d);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] d, input logic r);
        in_valid = v;
        in_data  = d;
        reset    = r;
        @(posedge clk);
        model_edge(v, d, r);
        #1;
        chk("tx",       {7'd0, out_tx},       {7'd0, (wave.size() > 0) ? wave[0] : 1'b1});
        chk("count",    {5'd0, out_count},    8'(mq.size()));
        chk("busy",     {7'd0, out_busy},     {7'd0, (wave.size() > 0) || (mq.size() > 0)});
        chk("overflow", {7'd0, out_overflow}, {7'd0, m_ovf});
    endtask

    initial begin
        logic line [1:30];
        int   busy_cycles;
        int   zeros;

        vecs[0] = '{4'b1100, 7'b1011000};
        vecs[1] = '{4'b0111, 7'b1101110};
        vecs[2] = '{4'b0000, 7'b1000000};
        vecs[3] = '{4'b1111, 7'b1011110};
        vecs[4] = '{4'b1010, 7'b1010100};
        vecs[5] = '{4'b0001, 7'b1100010};

        in_valid = 1'b0;
        in_data  = '0;
        reset    = 1'b1;

        // Reset state, with a write coincident with reset ignored
        step(1'b0, 4'h0, 1'b1);
        step(1'b1, 4'h5, 1'b1);
        chk("rst_tx",    {7'd0, out_tx},       8'd1);
        chk("rst_count", {5'd0, out_count},    8'd0);
        chk("rst_busy",  {7'd0, out_busy},     8'd0);
        chk("rst_ovf",   {7'd0, out_overflow}, 8'd0);
        step(1'b0, 4'h0, 1'b0);

        // Single-frame table: waveform per bit period and 28-cycle frame length
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vecs[i].data, 1'b0);
            chk("vec_tx_before_start", {7'd0, out_tx}, 8'd1);
            for (int k = 1; k <= 29; k++) begin
                step(1'b0, 4'h0, 1'b0);
                line[k] = out_tx;
                if (k == 28) chk("vec_busy_last", {7'd0, out_busy}, 8'd1);
                if (k == 29) chk("vec_busy_after", {7'd0, out_busy}, 8'd0);
            end
            for (int k = 1; k <= 28; k++)
                chk($sformatf("vec%0d_bit%0d", i, (k - 1) / C),
                    {7'd0, line[k]}, {7'd0, vecs[i].bits[(k - 1) / C]});
            chk("vec_idle_tx", {7'd0, line[29]}, 8'd1);
        end

        // Six back-to-back writes: sixth dropped, five frames with no idle gap
        step(1'b0, 4'h0, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 4'(i), 1'b0);
            if (i == 5) chk("burst_count5", {5'd0, out_count}, 8'd4);
            if (i == 5) chk("burst_ovf5", {7'd0, out_overflow}, 8'd0);
            if (i == 6) chk("burst_ovf6", {7'd0, out_overflow}, 8'd1);
            if (i == 6) chk("burst_count6", {5'd0, out_count}, 8'd4);
        end
        busy_cycles = 6;
        for (int k = 0; k < 300; k++) begin
            step(1'b0, 4'h0, 1'b0);
            if (k == 0) chk("burst_ovf_clear", {7'd0, out_overflow}, 8'd0);
            if (!out_busy) break;
            busy_cycles++;
        end
        chk("burst_busy_cycles", 8'(busy_cycles), 8'd141);

        // Write while full on the edge that pops at end of STOP
        step(1'b0, 4'h0, 1'b1);
        for (int i = 1; i <= 5; i++) step(1'b1, 4'(8 + i), 1'b0);
        for (int i = 6; i <= 29; i++) step(1'b0, 4'h0, 1'b0);
        chk("popfull_pre_count", {5'd0, out_count}, 8'd4);
        step(1'b1, 4'he, 1'b0);
        chk("popfull_count", {5'd0, out_count}, 8'd4);
        chk("popfull_ovf", {7'd0, out_overflow}, 8'd0);
        chk("popfull_tx_start", {7'd0, out_tx}, 8'd0);
        for (int i = 0; i < 200; i++) step(1'b0, 4'h0, 1'b0);

        // Reset during DATA bit 2 with two nibbles queued
        step(1'b0, 4'h0, 1'b1);
        for (int i = 1; i <= 3; i++) step(1'b1, 4'(2 + i), 1'b0);
        chk("abort_queued", {5'd0, out_count}, 8'd2);
        for (int i = 4; i <= 15; i++) step(1'b0, 4'h0, 1'b0);
        step(1'b1, 4'h7, 1'b1);
        chk("abort_tx", {7'd0, out_tx}, 8'd1);
        chk("abort_count", {5'd0, out_count}, 8'd0);
        chk("abort_busy", {7'd0, out_busy}, 8'd0);
        zeros = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'h0, 1'b0);
            if (!out_tx) zeros++;
        end
        chk("abort_no_frames", 8'(zeros), 8'd0);

        // in_data toggling with in_valid low
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'($urandom), 1'b0);
            chk("quiet_tx", {7'd0, out_tx}, 8'd1);
            chk("quiet_count", {5'd0, out_count}, 8'd0);
        end

        // Random traffic: heavy phase keeps the FIFO full, light phase drains it
        for (int i = 0; i < 4000; i++) begin
            logic v;
            logic r;
            v = (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 599) == 0);
            step(v, 4'($urandom), r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
